// File: rtl/isa_test_mon_pkg.sv
// rtl/isa_test_mon_pkg.sv - shared state encoding and register-index constants for the ISA test monitor
package isa_test_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TOUT = 2'd3
  } mon_state_e;

  localparam int DEF_END_REG = 26;
  localparam int DEF_RES_REG = 27;
  localparam int DEF_NUM_REG = 3;

  localparam logic [31:0] PASS_VAL = 32'h1;

endpackage

// File: rtl/isa_test_hart_snoop.sv
// rtl/isa_test_hart_snoop.sv - per-hart regfile write snooper: result/number shadows and sticky end flag
module isa_test_hart_snoop
  import isa_test_mon_pkg::*;
#(
  parameter int END_REG = DEF_END_REG,
  parameter int RES_REG = DEF_RES_REG,
  parameter int NUM_REG = DEF_NUM_REG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        active,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  output logic        end_nxt,
  output logic [31:0] res_nxt,
  output logic [31:0] num_nxt
);

  localparam logic [4:0] END_IDX = 5'(END_REG);
  localparam logic [4:0] RES_IDX = 5'(RES_REG);
  localparam logic [4:0] NUM_IDX = 5'(NUM_REG);

  logic        end_q;
  logic [31:0] res_q;
  logic [31:0] num_q;
  logic        hit;

  assign hit = active && we && (waddr != 5'd0);

  // Next-state values are exported so the top can resolve a write landing in the finishing cycle.
  always_comb begin
    end_nxt = end_q;
    res_nxt = res_q;
    num_nxt = num_q;
    if (hit) begin
      if (waddr == RES_IDX) res_nxt = wdata;
      if (waddr == NUM_IDX) num_nxt = wdata;
      if (waddr == END_IDX && wdata == 32'd1) end_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      end_q <= 1'b0;
      res_q <= '0;
      num_q <= '0;
    end else begin
      end_q <= end_nxt;
      res_q <= res_nxt;
      num_q <= num_nxt;
    end
  end

endmodule

// File: rtl/isa_test_monitor.sv
// rtl/isa_test_monitor.sv - multi-hart ISA test-end monitor; optional trap injector under ISA_TEST_MON_TRAP_INJ_EN
module isa_test_monitor
  import isa_test_mon_pkg::*;
#(
  parameter int NHART       = 1,
  parameter int TIMEOUT_W   = 24,
  parameter int TIMEOUT_CYC = 30000,
  parameter int END_REG     = DEF_END_REG,
  parameter int RES_REG     = DEF_RES_REG,
  parameter int NUM_REG     = DEF_NUM_REG,
  parameter int TRAP_DLY    = 30,
  parameter int TRAP_LEN    = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [NHART-1:0]      we_i,
  input  logic [5*NHART-1:0]    waddr_i,
  input  logic [32*NHART-1:0]   wdata_i,
  input  logic [NHART-1:0]      mends_i,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic                  fail_o,
  output logic                  timeout_o,
  output logic                  sw_end_o,
  output logic [31:0]           fail_num_o,
  output logic [1:0]            fail_hart_o,
  output logic                  ex_trap_o
);

  localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

  mon_state_e           state;
  logic [TIMEOUT_W-1:0] cnt;
  logic                 in_run;
  logic                 arm;
  logic [NHART-1:0]     end_nxt;
  logic [31:0]          res_nxt [NHART];
  logic [31:0]          num_nxt [NHART];
  logic                 all_end;
  logic                 all_pass;
  logic                 mends_any;
  logic                 to_hit;
  logic                 run_exit;
  logic [1:0]           fail_hart_sel;
  logic [31:0]          fail_num_sel;

  assign in_run  = (state == RUN);
  assign arm     = start_i && !in_run;
  assign state_o = state;

  for (genvar h = 0; h < NHART; h++) begin : g_hart
    isa_test_hart_snoop #(
      .END_REG (END_REG),
      .RES_REG (RES_REG),
      .NUM_REG (NUM_REG)
    ) u_snoop (
      .clk     (clk),
      .rst     (rst),
      .clr     (arm),
      .active  (in_run),
      .we      (we_i[h]),
      .waddr   (waddr_i[5*h +: 5]),
      .wdata   (wdata_i[32*h +: 32]),
      .end_nxt (end_nxt[h]),
      .res_nxt (res_nxt[h]),
      .num_nxt (num_nxt[h])
    );
  end

  // Walk from the top hart down so the lowest failing index wins.
  always_comb begin
    all_pass      = 1'b1;
    fail_hart_sel = 2'd0;
    fail_num_sel  = 32'd0;
    for (int h = NHART - 1; h >= 0; h--) begin
      if (res_nxt[h] != PASS_VAL) begin
        all_pass      = 1'b0;
        fail_hart_sel = 2'(h);
        fail_num_sel  = num_nxt[h];
      end
    end
  end

  assign all_end   = &end_nxt;
  assign mends_any = |mends_i;
  assign to_hit    = (cnt == TO_LAST);
  assign run_exit  = all_end || mends_any || to_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      done_o      <= 1'b0;
      pass_o      <= 1'b0;
      fail_o      <= 1'b0;
      timeout_o   <= 1'b0;
      sw_end_o    <= 1'b0;
      fail_num_o  <= '0;
      fail_hart_o <= '0;
    end else begin
      case (state)
        RUN: begin
          if (all_end) begin
            state       <= DONE;
            done_o      <= 1'b1;
            pass_o      <= all_pass;
            fail_o      <= !all_pass;
            fail_hart_o <= fail_hart_sel;
            fail_num_o  <= fail_num_sel;
          end else if (mends_any) begin
            state    <= DONE;
            done_o   <= 1'b1;
            sw_end_o <= 1'b1;
          end else if (to_hit) begin
            state     <= TOUT;
            done_o    <= 1'b1;
            timeout_o <= 1'b1;
          end else begin
            cnt <= cnt + TIMEOUT_W'(1);
          end
        end
        default: begin
          if (start_i) begin
            state       <= RUN;
            cnt         <= '0;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
            sw_end_o    <= 1'b0;
            fail_num_o  <= '0;
            fail_hart_o <= '0;
          end
        end
      endcase
    end
  end

`ifdef ISA_TEST_MON_TRAP_INJ_EN
  localparam int             TW     = $clog2(TRAP_DLY + TRAP_LEN + 2) + 1;
  localparam logic [TW-1:0]  WIN_LO = TW'(TRAP_DLY);
  localparam logic [TW-1:0]  WIN_HI = TW'(TRAP_DLY + TRAP_LEN);

  logic [TW-1:0] trap_cnt;
  logic [TW-1:0] trap_look;

  // Counter parks at WIN_HI once the pulse window has passed.
  assign trap_look = (trap_cnt == WIN_HI) ? trap_cnt : trap_cnt + TW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      trap_cnt  <= '0;
      ex_trap_o <= 1'b0;
    end else if (arm) begin
      trap_cnt  <= '0;
      ex_trap_o <= (WIN_LO == '0) && (WIN_HI != '0);
    end else if (in_run) begin
      trap_cnt  <= trap_look;
      ex_trap_o <= !run_exit && (trap_look >= WIN_LO) && (trap_look < WIN_HI);
    end else begin
      ex_trap_o <= 1'b0;
    end
  end
`else
  logic unused_trap_cfg;
  assign unused_trap_cfg = ^{TRAP_DLY, TRAP_LEN, run_exit};
  assign ex_trap_o       = 1'b0;
`endif

endmodule

// File: tb/tb_isa_test_monitor.sv
// tb/tb_isa_test_monitor.sv - directed self-checking bench for isa_test_monitor (NHART=1 and NHART=2 instances)
module tb_isa_test_monitor;

  logic        clk;
  logic        rst;
  logic        start;

  logic        we1;
  logic [4:0]  waddr1;
  logic [31:0] wdata1;
  logic        mends1;
  logic [1:0]  state1;
  logic        done1, pass1, fail1, timeout1, sw_end1, ex_trap1;
  logic [31:0] fail_num1;
  logic [1:0]  fail_hart1;

  logic [1:0]  we2;
  logic [9:0]  waddr2;
  logic [63:0] wdata2;
  logic [1:0]  mends2;
  logic [1:0]  state2;
  logic        done2, pass2, fail2, timeout2, sw_end2, ex_trap2;
  logic [31:0] fail_num2;
  logic [1:0]  fail_hart2;

  int checks = 0;
  int errors = 0;

  isa_test_monitor #(.NHART(1), .TIMEOUT_CYC(100)) dut1 (
    .clk(clk), .rst(rst), .start_i(start), .we_i(we1), .waddr_i(waddr1), .wdata_i(wdata1),
    .mends_i(mends1), .state_o(state1), .done_o(done1), .pass_o(pass1), .fail_o(fail1),
    .timeout_o(timeout1), .sw_end_o(sw_end1), .fail_num_o(fail_num1),
    .fail_hart_o(fail_hart1), .ex_trap_o(ex_trap1)
  );

  isa_test_monitor #(.NHART(2), .TIMEOUT_CYC(100), .TRAP_DLY(30), .TRAP_LEN(7)) dut2 (
    .clk(clk), .rst(rst), .start_i(start), .we_i(we2), .waddr_i(waddr2), .wdata_i(wdata2),
    .mends_i(mends2), .state_o(state2), .done_o(done2), .pass_o(pass2), .fail_o(fail2),
    .timeout_o(timeout2), .sw_end_o(sw_end2), .fail_num_o(fail_num2),
    .fail_hart_o(fail_hart2), .ex_trap_o(ex_trap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we1 = 1'b0; waddr1 = '0; wdata1 = '0; mends1 = 1'b0;
    we2 = '0;   waddr2 = '0; wdata2 = '0; mends2 = '0;
  endtask

  task automatic w2(input int h, input int idx, input logic [31:0] d);
    we2[h]            = 1'b1;
    waddr2[5*h +: 5]  = idx[4:0];
    wdata2[32*h +: 32] = d;
  endtask

  task automatic arm();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  function automatic logic trap_exp(input int k);
`ifdef ISA_TEST_MON_TRAP_INJ_EN
    return (k >= 30) && (k <= 36);
`else
    return 1'b0;
`endif
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; idle_in();
    step(); step();
    chk("rst_state2", state2, 0);
    chk("rst_done2", done2, 0);
    chk("rst_pass2", pass2, 0);
    chk("rst_fail2", fail2, 0);
    chk("rst_tout2", timeout2, 0);
    chk("rst_swend2", sw_end2, 0);
    chk("rst_fnum2", fail_num2, 0);
    chk("rst_fhart2", fail_hart2, 0);
    chk("rst_trap2", ex_trap2, 0);
    chk("rst_state1", state1, 0);
    rst = 1'b0;

    // Pass on NHART=1, fail on hart1 of NHART=2
    arm();
    chk("arm_state1", state1, 1);
    chk("arm_state2", state2, 1);
    we1 = 1'b1; waddr1 = 5'd27; wdata1 = 32'd1;
    w2(0, 27, 32'd1); w2(1, 3, 32'd5);
    step(); idle_in();
    we1 = 1'b1; waddr1 = 5'd26; wdata1 = 32'd1;
    w2(0, 26, 32'd1); w2(1, 27, 32'd0);
    step(); idle_in();
    chk("p1_state", state1, 2);
    chk("p1_done", done1, 1);
    chk("p1_pass", pass1, 1);
    chk("p1_fail", fail1, 0);
    chk("f2_early_done", done2, 0);
    chk("f2_early_state", state2, 1);
    w2(1, 26, 32'd1);
    step(); idle_in();
    chk("f2_done", done2, 1);
    chk("f2_fail", fail2, 1);
    chk("f2_pass", pass2, 0);
    chk("f2_hart", fail_hart2, 1);
    chk("f2_num", fail_num2, 5);
    chk("f2_state", state2, 2);
    step();
    chk("f2_hold_num", fail_num2, 5);

    // Result written in the same cycle as the last end flag
    arm();
    chk("c_state", state2, 1);
    chk("c_fail_clr", fail2, 0);
    chk("c_num_clr", fail_num2, 0);
    chk("c_hart_clr", fail_hart2, 0);
    w2(0, 27, 32'd0); w2(1, 27, 32'd1);
    step(); idle_in();
    w2(0, 26, 32'd1);
    step(); idle_in();
    chk("c_not_done", done2, 0);
    w2(0, 27, 32'd1); w2(1, 26, 32'd1);
    step(); idle_in();
    chk("c_done", done2, 1);
    chk("c_pass", pass2, 1);
    chk("c_fail", fail2, 0);

    // Timeout: non-1 end value and x0 writes must not end the test
    arm();
    w2(0, 26, 32'd2); w2(1, 26, 32'd2);
    step(); idle_in();
    w2(0, 0, 32'd1); w2(1, 0, 32'd1);
    step(); idle_in();
    repeat (97) step();
    chk("t_pre_state", state2, 1);
    chk("t_pre_tout", timeout2, 0);
    step();
    chk("t_tout2", timeout2, 1);
    chk("t_state2", state2, 3);
    chk("t_done2", done2, 1);
    chk("t_pass2", pass2, 0);
    chk("t_fail2", fail2, 0);
    chk("t_tout1", timeout1, 1);

    // Software end via mends, then re-arm
    arm();
    step();
    mends2 = 2'b10;
    step(); idle_in();
    chk("m_swend", sw_end2, 1);
    chk("m_done", done2, 1);
    chk("m_pass", pass2, 0);
    chk("m_fail", fail2, 0);
    chk("m_state", state2, 2);
    arm();
    chk("ra_state", state2, 1);
    chk("ra_swend", sw_end2, 0);
    chk("ra_done", done2, 0);
    chk("ra_tout", timeout2, 0);
    w2(0, 27, 32'd1); w2(1, 27, 32'd1);
    step(); idle_in();
    w2(0, 26, 32'd1); w2(1, 26, 32'd1); mends2 = 2'b01;
    step(); idle_in();
    chk("pr_pass", pass2, 1);
    chk("pr_swend", sw_end2, 0);
    chk("pr_state", state2, 2);

    // Last end flag coincides with the final timeout cycle
    arm();
    w2(0, 27, 32'd1); w2(1, 27, 32'd1);
    step(); idle_in();
    w2(0, 26, 32'd1);
    step(); idle_in();
    repeat (97) step();
    chk("e_pre_state", state2, 1);
    w2(1, 26, 32'd1);
    step(); idle_in();
    chk("e_done", done2, 1);
    chk("e_pass", pass2, 1);
    chk("e_tout", timeout2, 0);
    chk("e_state", state2, 2);

    // Trap pulse window, then reset in the middle of it
    arm();
    for (int k = 1; k <= 40; k++) begin
      step();
      chk($sformatf("trap_k%0d", k), ex_trap2, trap_exp(k));
    end
    mends2 = 2'b01;
    step(); idle_in();
    chk("trap_left_run", ex_trap2, 0);
    chk("trap_left_state", state2, 2);
    arm();
    for (int k = 1; k <= 33; k++) begin
      step();
      chk($sformatf("trap2_k%0d", k), ex_trap2, trap_exp(k));
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rr_trap", ex_trap2, 0);
    chk("rr_state", state2, 0);
    chk("rr_done", done2, 0);
    chk("rr_trap1", ex_trap1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isa_test_monitor.md
# isa_test_monitor

Synthesizable multi-hart test-result monitor for the SparrowRV SoC. It snoops each hart's register-file write port and detects the ISA-test end convention: x26 written with 1 ends the test, x27 == 1 means pass, and x3 holds the failing test number. It also watches the CSR `mends` software-end flag and runs a saturating timeout. Results are registered status outputs for LEDs/UART on FPGA or for bench checking, with an optional external-trap stimulus pulse after arming.

## Interface
Parameters:
- `NHART`, 1: number of monitored harts (1..4).
- `TIMEOUT_W`, 24: timeout counter width.
- `TIMEOUT_CYC`, 30000: cycles in RUN before timeout; must be < 2^TIMEOUT_W.
- `END_REG`, 26: end-flag register index.
- `RES_REG`, 27: result register index.
- `NUM_REG`, 3: test-number register index.
- `TRAP_DLY`, 30: cycles from arm to trap pulse start (trap-injector build only).
- `TRAP_LEN`, 7: trap pulse length in cycles (trap-injector build only).

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `start_i` in 1: arm/re-arm pulse.
- `we_i` in NHART: per-hart regfile write enable.
- `waddr_i` in 5*NHART: per-hart write index; hart h uses bits [5h+4:5h].
- `wdata_i` in 32*NHART: per-hart write data.
- `mends_i` in NHART: per-hart CSR mends flag.
- `state_o` out 2: FSM state.
- `done_o` out 1: test finished (any cause).
- `pass_o` out 1: all harts ended with result 1.
- `fail_o` out 1: at least one hart ended with result ≠ 1.
- `timeout_o` out 1: timeout expired.
- `sw_end_o` out 1: ended by mends.
- `fail_num_o` out 32: NUM_REG shadow of the failing hart.
- `fail_hart_o` out 2: index of the failing hart.
- `ex_trap_o` out 1: trap stimulus (0 when the injector is compiled out).

## Operation
- FSM states: IDLE(0), RUN(1), DONE(2), TOUT(3).
- IDLE→RUN on `start_i`. Arming clears all shadows, end flags, status outputs and the counter.
- DONE/TOUT→RUN on `start_i` (re-arm, same clearing). `start_i` in RUN is ignored.
- Per hart, in RUN only: if `we_i[h]` and the index ≠ 0:
  - index == RES_REG: load the result shadow.
  - index == NUM_REG: load the number shadow.
  - index == END_REG and data == 1: set the sticky end flag.
  - END_REG written with any other value: no effect.
- Writes are ignored outside RUN and to x0.
- RUN→DONE when all NHART end flags are set.
  - `pass_o` = all result shadows == 1; `fail_o` = !pass.
  - On fail: `fail_hart_o` = lowest failing hart index, `fail_num_o` = that hart's number shadow.
- RUN→DONE when any `mends_i` bit is 1: `sw_end_o` = 1, pass/fail = 0.
- RUN→TOUT when the counter reaches TIMEOUT_CYC-1: `timeout_o` = 1. The counter increments only in RUN.
- Priority in the same cycle: all-ended > mends > timeout.
- Status outputs hold until re-arm or reset.

## Timing
- Reset values: `state_o` = 0; all flags 0; `fail_num_o` = 0; `fail_hart_o` = 0; `ex_trap_o` = 0; shadows 0.
- Snooped write in cycle N updates the shadow at edge N+1.
- The END_REG write completing the last flag in cycle N gives `done_o`, `pass_o`/`fail_o` and `state_o` = 2 visible from cycle N+1. A result write to another hart in that same cycle N is included in the pass/fail evaluation.
- `mends_i` high in RUN during cycle N gives `done_o` and `sw_end_o` from N+1.
- Timeout: `timeout_o` rises exactly TIMEOUT_CYC cycles after the arming edge.
- `rst` mid-RUN returns to IDLE at the next edge and clears everything. `rst` has priority over `start_i`.

## Configuration
- Macro `ISA_TEST_MON_TRAP_INJ_EN`.
- Defined:
  - A delay counter starts at arm.
  - `ex_trap_o` is high for cycles TRAP_DLY..TRAP_DLY+TRAP_LEN-1 after the arming edge, only while in RUN.
  - Re-arm restarts the sequence.
  - Leaving RUN forces `ex_trap_o` to 0.
- Undefined: `ex_trap_o` is tied 0 and there is no delay counter.

## Structure
- Package `isa_test_mon_pkg`: state enum (IDLE/RUN/DONE/TOUT), default register-index constants, `PASS_VAL` = 32'h1.
- Sub-module `isa_test_hart_snoop`, one instance per hart: index decode, result/number shadows, sticky end flag.
- Top level: FSM, timeout counter, fail-hart priority encoder, trap injector.

## Test plan
- NHART=1: arm, write x27=1, then x26=1 → `done_o` = `pass_o` = 1 next cycle, `state_o` = 2.
- NHART=2: hart0 x27=1/x26=1; hart1 x3=5, x27=0, x26=1 → `fail_o` = 1, `fail_hart_o` = 1, `fail_num_o` = 5, `done_o` only after hart1 ends.
- x26=2 then x0 write of 1, no end → `timeout_o` = 1 exactly at TIMEOUT_CYC (set to 100 for the test) after arm, `state_o` = 3.
- `mends_i` pulse in RUN → `sw_end_o` = 1, `pass_o` = `fail_o` = 0. Re-arm with `start_i` → all status 0, `state_o` = 1.
- Trap macro defined, TRAP_DLY=30, TRAP_LEN=7 → `ex_trap_o` high exactly cycles 30..36 after arm. Assert `rst` at cycle 33 → `ex_trap_o` and `state_o` 0 next cycle.
- Last end write and counter reaching TIMEOUT_CYC-1 in the same cycle → DONE with pass, `timeout_o` = 0.
